ram_8x8_arbiter: RTL

- Two-requester, round-robin arbiter and sequencer that shares one RAM_8x8 instance between two client ports (P0, P1).
- Also runs a memory-init sequence that writes INIT_VALUE to every word.
- Sits between client logic and the RAM. It drives the RAM's rw, addr and data_in from registers and samples the RAM's data_out.
- The RAM's own clr input is not driven by this block; the integrator ties it inactive.

---
 rtl/ram_ctrl_pkg.sv | 25 ++
 rtl/ram_8x8_arbiter_rr_arb2.sv | 38 +++
 rtl/ram_8x8_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM_8x8 arbiter/sequencer.
// FSM state encoding, port-select encoding and default sizes.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACK,
    ST_INIT,
    ST_DONE
  } state_e;

  typedef enum logic {
    SEL_P0 = 1'b0,
    SEL_P1 = 1'b1
  } sel_e;

  function automatic sel_e other_port(sel_e s);
    return (s == SEL_P0) ? SEL_P1 : SEL_P0;
  endfunction

endpackage

// File: rtl/ram_8x8_arbiter_rr_arb2.sv
// Two-requester round-robin picker: combinational pick,
// registered pointer. Ports: clk, clr (async low), en, req0/1 -> valid, gnt (1 = P1).
import ram_ctrl_pkg::*;

module rr_arb2 (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic valid,
  output logic gnt
);

  sel_e ptr_q, ptr_d;
  sel_e pick;

  always_comb begin
    pick  = SEL_P0;
    ptr_d = ptr_q;
    if (req0 && req1) begin
      pick = ptr_q;
      // Only a real tie moves the pointer, to the loser.
      if (en) ptr_d = other_port(ptr_q);
    end else if (req1) begin
      pick = SEL_P1;
    end
  end

  assign valid = req0 | req1;
  assign gnt   = (pick == SEL_P1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) ptr_q <= SEL_P0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_8x8_arbiter.sv
// Shares one RAM_8x8 between ports P0/P1 (round-robin) and runs
// a full-memory init. Ports: clk, clr, req/we/addr/wdata/ack/rdata x2,
// init_req, busy, init_done, ram_rw/ram_addr/ram_din out, ram_dout in.
import ram_ctrl_pkg::*;

module ram_8x8_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              init_req,
  output logic              busy,
  output logic              init_done,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e state_q, state_d;
  sel_e   sel_q, sel_d, win;

  logic              pend_q, pend_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic arb_en, arb_valid, arb_gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .clr   (clr),
    .en    (arb_en),
    .req0  (req0),
    .req1  (req1),
    .valid (arb_valid),
    .gnt   (arb_gnt)
  );

  assign win = arb_gnt ? SEL_P1 : SEL_P0;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q | init_req;
    rw_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    arb_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_INIT;
          pend_d  = 1'b0;
          rw_d    = 1'b1;
          addr_d  = '0;
          din_d   = INIT_VALUE;
        end else if (arb_valid) begin
          arb_en  = 1'b1;
          state_d = ST_ACCESS;
          sel_d   = win;
          if (win == SEL_P1) begin
            rw_d   = we1;
            addr_d = addr1;
            din_d  = wdata1;
          end else begin
            rw_d   = we0;
            addr_d = addr0;
            din_d  = wdata0;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
        if (sel_q == SEL_P1) begin
          ack1_d = 1'b1;
          if (!rw_q) rd1_d = ram_dout;
        end else begin
          ack0_d = 1'b1;
          if (!rw_q) rd0_d = ram_dout;
        end
      end
      ST_ACK: state_d = ST_IDLE;
      ST_INIT: begin
        din_d  = INIT_VALUE;
        // ram_addr doubles as the init counter and wraps to 0.
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          rw_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_P0;
      pend_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done_q  <= done_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign init_done = done_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rd0_q;
  assign rdata1    = rd1_q;
  assign ram_rw    = rw_q;
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;

endmodule
